// File: rtl/mips_pkg.sv
// Shared MIPS encodings, ALU control codes and datapath defaults used by the
// ID/EX issue stage and its control decoder.
package mips_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_RA_W  = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b011;
    localparam logic [2:0] ALU_ANDN = 3'b100;
    localparam logic [2:0] ALU_ADDN = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    typedef enum logic [1:0] {
        IMM_REG  = 2'd0,
        IMM_SEXT = 2'd1,
        IMM_ZEXT = 2'd2
    } imm_sel_e;

    typedef enum logic {
        DEST_RT = 1'b0,
        DEST_RD = 1'b1
    } dest_sel_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode/funct decoder: ALU control code, operand-B source,
// destination field select, register-write enable and illegal flag.
module alu_ctrl_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] cntrl,
    output imm_sel_e   imm_sel,
    output dest_sel_e  dest_sel,
    output logic       regwrite,
    output logic       illegal
);

    always_comb begin
        cntrl    = ALU_ADD;
        imm_sel  = IMM_REG;
        dest_sel = DEST_RT;
        regwrite = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dest_sel = DEST_RD;
                regwrite = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: cntrl = ALU_ADD;
                    FN_SUB, FN_SUBU: cntrl = ALU_SUB;
                    FN_AND:          cntrl = ALU_AND;
                    FN_OR:           cntrl = ALU_OR;
                    FN_XOR:          cntrl = ALU_XOR;
                    FN_SLT, FN_SLTU: cntrl = ALU_SLT;
                    default: begin
                        regwrite = 1'b0;
                        illegal  = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW: begin
                imm_sel  = IMM_SEXT;
                regwrite = 1'b1;
            end
            OP_SLTI, OP_SLTIU: begin
                cntrl    = ALU_SLT;
                imm_sel  = IMM_SEXT;
                regwrite = 1'b1;
            end
            OP_ANDI: begin
                cntrl    = ALU_AND;
                imm_sel  = IMM_ZEXT;
                regwrite = 1'b1;
            end
            OP_ORI: begin
                cntrl    = ALU_OR;
                imm_sel  = IMM_ZEXT;
                regwrite = 1'b1;
            end
            OP_XORI: begin
                cntrl    = ALU_XOR;
                imm_sel  = IMM_ZEXT;
                regwrite = 1'b1;
            end
            OP_SW:   imm_sel = IMM_SEXT;
            OP_BEQ:  cntrl   = ALU_SUB;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register feeding the ALU: decode, operand-B select and
// EX/MEM > MEM/WB forwarding, with hazard-unit stall and flush.
module alu_issue_stage
    import mips_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int RA_W  = DEF_RA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic             stall,
    input  logic             flush,
    input  logic             exm_regwrite,
    input  logic [RA_W-1:0]  exm_dest,
    input  logic [WIDTH-1:0] exm_result,
    input  logic             mwb_regwrite,
    input  logic [RA_W-1:0]  mwb_dest,
    input  logic [WIDTH-1:0] mwb_result,
    output logic             ex_valid,
    output logic [2:0]       ex_cntrl,
    output logic [WIDTH-1:0] ex_a,
    output logic [WIDTH-1:0] ex_b,
    output logic [WIDTH-1:0] ex_store_data,
    output logic [RA_W-1:0]  ex_dest,
    output logic             ex_regwrite,
    output logic             ex_illegal
);

    logic [5:0]      opcode, funct;
    logic [RA_W-1:0] rs, rt, rd, dest;
    logic [15:0]     imm;
    logic [2:0]      dec_cntrl;
    imm_sel_e        imm_sel;
    dest_sel_e       dest_sel;
    logic            dec_regwrite, dec_illegal;
    logic [WIDTH-1:0] fwd_rs, fwd_rt, op_b;
    logic            unused_shamt;

    assign opcode = id_instr[31:26];
    assign funct  = id_instr[5:0];
    assign rs     = RA_W'(id_instr[25:21]);
    assign rt     = RA_W'(id_instr[20:16]);
    assign rd     = RA_W'(id_instr[15:11]);
    assign imm    = id_instr[15:0];
    assign unused_shamt = &{1'b0, id_instr[10:6]};

    alu_ctrl_decode u_dec (
        .opcode   (opcode),
        .funct    (funct),
        .cntrl    (dec_cntrl),
        .imm_sel  (imm_sel),
        .dest_sel (dest_sel),
        .regwrite (dec_regwrite),
        .illegal  (dec_illegal)
    );

    // Register 0 is hardwired, so it never matches a forwarding source.
    function automatic logic [WIDTH-1:0] fwd(input logic [RA_W-1:0] src,
                                             input logic [WIDTH-1:0] rf);
        if (src != '0 && exm_regwrite && exm_dest == src)
            return exm_result;
        else if (src != '0 && mwb_regwrite && mwb_dest == src)
            return mwb_result;
        else
            return rf;
    endfunction

    assign fwd_rs = fwd(rs, id_rs_data);
    assign fwd_rt = fwd(rt, id_rt_data);
    assign dest   = (dest_sel == DEST_RD) ? rd : rt;

    always_comb begin
        case (imm_sel)
            IMM_SEXT: op_b = {{(WIDTH-16){imm[15]}}, imm};
            IMM_ZEXT: op_b = {{(WIDTH-16){1'b0}}, imm};
            default:  op_b = fwd_rt;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush || (!stall && !id_valid)) begin
            ex_valid      <= 1'b0;
            ex_cntrl      <= '0;
            ex_a          <= '0;
            ex_b          <= '0;
            ex_store_data <= '0;
            ex_dest       <= '0;
            ex_regwrite   <= 1'b0;
            ex_illegal    <= 1'b0;
        end else if (!stall) begin
            ex_valid      <= 1'b1;
            ex_cntrl      <= dec_cntrl;
            ex_a          <= fwd_rs;
            ex_b          <= op_b;
            ex_store_data <= fwd_rt;
            ex_dest       <= dest;
            ex_regwrite   <= dec_regwrite && (dest != '0);
            ex_illegal    <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed-vector bench for alu_issue_stage with hand-computed expectations.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_instr, id_rs_data, id_rt_data;
    logic        stall, flush;
    logic        exm_regwrite, mwb_regwrite;
    logic [4:0]  exm_dest, mwb_dest;
    logic [31:0] exm_result, mwb_result;
    logic        ex_valid, ex_regwrite, ex_illegal;
    logic [2:0]  ex_cntrl;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [4:0]  ex_dest;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .stall(stall), .flush(flush),
        .exm_regwrite(exm_regwrite), .exm_dest(exm_dest), .exm_result(exm_result),
        .mwb_regwrite(mwb_regwrite), .mwb_dest(mwb_dest), .mwb_result(mwb_result),
        .ex_valid(ex_valid), .ex_cntrl(ex_cntrl), .ex_a(ex_a), .ex_b(ex_b),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest),
        .ex_regwrite(ex_regwrite), .ex_illegal(ex_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic issue(input logic [31:0] instr, input logic [31:0] rsd, input logic [31:0] rtd);
        @(negedge clk);
        id_valid   = 1'b1;
        id_instr   = instr;
        id_rs_data = rsd;
        id_rt_data = rtd;
        @(posedge clk);
        #1;
    endtask

    task automatic no_fwd();
        exm_regwrite = 1'b0; exm_dest = 5'd0; exm_result = 32'h0;
        mwb_regwrite = 1'b0; mwb_dest = 5'd0; mwb_result = 32'h0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".valid"}, {31'd0, ex_valid}, 32'd0);
        chk({tag, ".regwrite"}, {31'd0, ex_regwrite}, 32'd0);
        chk({tag, ".illegal"}, {31'd0, ex_illegal}, 32'd0);
        chk({tag, ".a"}, ex_a, 32'd0);
        chk({tag, ".b"}, ex_b, 32'd0);
        chk({tag, ".dest"}, {27'd0, ex_dest}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_instr = 32'h0;
        id_rs_data = 32'h0; id_rt_data = 32'h0; stall = 1'b0; flush = 1'b0;
        no_fwd();
        #12;
        chk_all_zero("reset");
        @(negedge clk); rst = 1'b0;

        // add $3,$1,$2
        issue(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7);
        chk("add.valid", {31'd0, ex_valid}, 32'd1);
        chk("add.cntrl", {29'd0, ex_cntrl}, 32'd2);
        chk("add.a", ex_a, 32'd5);
        chk("add.b", ex_b, 32'd7);
        chk("add.store", ex_store_data, 32'd7);
        chk("add.dest", {27'd0, ex_dest}, 32'd3);
        chk("add.regwrite", {31'd0, ex_regwrite}, 32'd1);
        chk("add.illegal", {31'd0, ex_illegal}, 32'd0);

        // Reset asserted between edges must clear immediately
        @(negedge clk); #2 rst = 1'b1; #1;
        chk_all_zero("rst_mid");
        #1 rst = 1'b0;

        issue(itype(6'h08, 5'd1, 5'd4, 16'hFFFF), 32'd5, 32'd7);
        chk("addi.b", ex_b, 32'hFFFF_FFFF);
        chk("addi.cntrl", {29'd0, ex_cntrl}, 32'd2);
        chk("addi.dest", {27'd0, ex_dest}, 32'd4);
        chk("addi.regwrite", {31'd0, ex_regwrite}, 32'd1);

        issue(itype(6'h0C, 5'd1, 5'd4, 16'hFFFF), 32'd5, 32'd7);
        chk("andi.b", ex_b, 32'h0000_FFFF);
        chk("andi.cntrl", {29'd0, ex_cntrl}, 32'd0);

        issue(itype(6'h0E, 5'd1, 5'd4, 16'h8001), 32'd5, 32'd7);
        chk("xori.b", ex_b, 32'h0000_8001);
        chk("xori.cntrl", {29'd0, ex_cntrl}, 32'd3);

        issue(itype(6'h0B, 5'd1, 5'd4, 16'h8001), 32'd5, 32'd7);
        chk("sltiu.b", ex_b, 32'hFFFF_8001);
        chk("sltiu.cntrl", {29'd0, ex_cntrl}, 32'd7);

        issue(rtype(5'd1, 5'd2, 5'd3, 6'h23), 32'd5, 32'd7);
        chk("subu.cntrl", {29'd0, ex_cntrl}, 32'd6);
        issue(rtype(5'd1, 5'd2, 5'd3, 6'h2A), 32'd5, 32'd7);
        chk("slt.cntrl", {29'd0, ex_cntrl}, 32'd7);
        issue(rtype(5'd1, 5'd2, 5'd3, 6'h25), 32'd5, 32'd7);
        chk("or.cntrl", {29'd0, ex_cntrl}, 32'd1);

        // Forwarding: EX/MEM beats MEM/WB
        exm_regwrite = 1'b1; exm_dest = 5'd1; exm_result = 32'hAA;
        mwb_regwrite = 1'b1; mwb_dest = 5'd1; mwb_result = 32'hBB;
        issue(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7);
        chk("fwd_both.a", ex_a, 32'hAA);
        chk("fwd_both.b", ex_b, 32'd7);
        exm_regwrite = 1'b0;
        issue(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7);
        chk("fwd_mwb.a", ex_a, 32'hBB);
        mwb_dest = 5'd2;
        issue(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7);
        chk("fwd_mwb_rt.b", ex_b, 32'hBB);
        chk("fwd_mwb_rt.a", ex_a, 32'd5);
        // Register 0 is never forwarded
        exm_regwrite = 1'b1; exm_dest = 5'd0; mwb_dest = 5'd0;
        issue(rtype(5'd0, 5'd2, 5'd3, 6'h20), 32'h55, 32'd7);
        chk("fwd_r0.a", ex_a, 32'h55);
        no_fwd();

        // beq uses forwarded rt for B, no write
        exm_regwrite = 1'b1; exm_dest = 5'd2; exm_result = 32'h1234;
        issue(itype(6'h04, 5'd1, 5'd2, 16'h0010), 32'd5, 32'd7);
        chk("beq.cntrl", {29'd0, ex_cntrl}, 32'd6);
        chk("beq.b", ex_b, 32'h1234);
        chk("beq.regwrite", {31'd0, ex_regwrite}, 32'd0);

        // sw: B = sext imm, store data = forwarded rt
        exm_result = 32'hCC;
        issue(itype(6'h2B, 5'd1, 5'd2, 16'hFFF8), 32'd5, 32'd7);
        chk("sw.b", ex_b, 32'hFFFF_FFF8);
        chk("sw.store", ex_store_data, 32'hCC);
        chk("sw.regwrite", {31'd0, ex_regwrite}, 32'd0);
        chk("sw.cntrl", {29'd0, ex_cntrl}, 32'd2);
        no_fwd();

        issue(rtype(5'd1, 5'd2, 5'd3, 6'h3F), 32'd5, 32'd7);
        chk("ill_fn.illegal", {31'd0, ex_illegal}, 32'd1);
        chk("ill_fn.regwrite", {31'd0, ex_regwrite}, 32'd0);
        chk("ill_fn.valid", {31'd0, ex_valid}, 32'd1);
        chk("ill_fn.cntrl", {29'd0, ex_cntrl}, 32'd2);
        issue(itype(6'h3F, 5'd1, 5'd2, 16'h0), 32'd5, 32'd7);
        chk("ill_op.illegal", {31'd0, ex_illegal}, 32'd1);

        // Writes to $0 are suppressed
        issue(rtype(5'd1, 5'd2, 5'd0, 6'h20), 32'd5, 32'd7);
        chk("dest0.regwrite", {31'd0, ex_regwrite}, 32'd0);

        // id_valid low loads a bubble
        @(negedge clk); id_valid = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("bubble");

        // Stall holds through changing inputs and forwarding
        issue(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7);
        @(negedge clk);
        stall = 1'b1; id_instr = itype(6'h0C, 5'd4, 5'd6, 16'h00FF);
        id_rs_data = 32'h99; id_rt_data = 32'h77;
        exm_regwrite = 1'b1; exm_dest = 5'd1; exm_result = 32'hDEAD;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall.a", ex_a, 32'd5);
            chk("stall.b", ex_b, 32'd7);
            chk("stall.cntrl", {29'd0, ex_cntrl}, 32'd2);
            chk("stall.dest", {27'd0, ex_dest}, 32'd3);
            chk("stall.valid", {31'd0, ex_valid}, 32'd1);
        end
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("stall_flush");
        @(negedge clk); stall = 1'b0; flush = 1'b0; no_fwd();

        // Flush alone overrides a valid load
        @(negedge clk); flush = 1'b1; id_valid = 1'b1; id_instr = rtype(5'd1, 5'd2, 5'd3, 6'h20);
        @(posedge clk); #1;
        chk_all_zero("flush");
        @(negedge clk); flush = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
